// File: rtl/re_quad_gen.sv
// re_quad_gen: quadrature (A/B) waveform generator.
// Walks an internal position toward a loaded target level. Each detent is one
// full Gray cycle on A/B. The counting matches the rotary-encoder decoder:
// A rising with B=0 counts +1 (CW), and A rising with B=1 counts -1 (CCW).
//
// State table:
//   IDLE | no detent in flight; departs when pos != target_q
//   Q1   | first quarter  (CW: AB=10, pos+1 on entry / CCW: AB=01)
//   Q2   | second quarter (AB=11; CCW: pos-1 on entry)
//   Q3   | third quarter  (CW: AB=01 / CCW: AB=10)
//   Q4   | fourth quarter (AB=00); at exit, either start the next detent or finish
//
// Ports:
//   clk    in   system clock, posedge
//   reset  in   asynchronous active-high reset
//   target in   requested level, captured when load=1
//   load   in   1-cycle strobe that captures target into target_q
//   a, b   out  quadrature channels (registered)
//   pos    out  position emitted so far
//   busy   out  high while a detent is in progress
//   done   out  1-cycle pulse on return to IDLE
module re_quad_gen #(
    parameter int PHASE_CYCLES = 16,
    parameter int LEVEL_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] target,
    input  logic               load,
    output logic               a,
    output logic               b,
    output logic [LEVEL_W-1:0] pos,
    output logic               busy,
    output logic               done
);

    localparam int TW = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PHASE_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_Q1   = 3'd1;
    localparam logic [2:0] S_Q2   = 3'd2;
    localparam logic [2:0] S_Q3   = 3'd3;
    localparam logic [2:0] S_Q4   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [LEVEL_W-1:0] pos_q, pos_d;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               phase_end;
    logic               go_cw;

    assign phase_end = (timer_q == TIMER_LAST);
    assign go_cw     = (target_q > pos_q);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pos_d    = pos_q;
        a_d      = a_q;
        b_d      = b_q;
        dir_d    = dir_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        // A load updates target_q on the next cycle, so the decisions below
        // always use the target_q value that is visible in the current cycle.
        target_d = load ? target : target_q;

        case (state_q)
            S_IDLE: begin
                if (pos_q != target_q) begin
                    state_d = S_Q1;
                    timer_d = '0;
                    busy_d  = 1'b1;
                    dir_d   = go_cw;
                    if (go_cw) begin
                        a_d   = 1'b1;
                        b_d   = 1'b0;
                        pos_d = pos_q + LEVEL_W'(1);
                    end else begin
                        a_d = 1'b0;
                        b_d = 1'b1;
                    end
                end
            end
            S_Q1: begin
                if (phase_end) begin
                    state_d = S_Q2;
                    timer_d = '0;
                    a_d     = 1'b1;
                    b_d     = 1'b1;
                    // In CCW the A rise happens here, while B is already high.
                    if (!dir_q) pos_d = pos_q - LEVEL_W'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_Q2: begin
                if (phase_end) begin
                    state_d = S_Q3;
                    timer_d = '0;
                    a_d     = !dir_q;
                    b_d     = dir_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_Q3: begin
                if (phase_end) begin
                    state_d = S_Q4;
                    timer_d = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_Q4: begin
                if (phase_end) begin
                    timer_d = '0;
                    if (pos_q != target_q) begin
                        // Start the next detent with no idle gap. The direction
                        // is evaluated again here, which handles a retarget
                        // to the other side of pos.
                        state_d = S_Q1;
                        dir_d   = go_cw;
                        if (go_cw) begin
                            a_d   = 1'b1;
                            b_d   = 1'b0;
                            pos_d = pos_q + LEVEL_W'(1);
                        end else begin
                            a_d = 1'b0;
                            b_d = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            pos_q    <= '0;
            target_q <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign pos  = pos_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_re_quad_gen.sv
// Directed bench for re_quad_gen with PHASE_CYCLES=4, plus a reference
// decoder used for a loopback run with random targets.
module tb_re_quad_gen;

    localparam int P = 4;

    logic       clk;
    logic       reset;
    logic [7:0] target;
    logic       load;
    logic       a, b;
    logic [7:0] pos;
    logic       busy, done;

    int tests;
    int fails;

    re_quad_gen #(.PHASE_CYCLES(P), .LEVEL_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .target (target),
        .load   (load),
        .a      (a),
        .b      (b),
        .pos    (pos),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder. It samples A through a register and counts on an A
    // rise, using B to choose the direction.
    logic       dec_a_q;
    logic [7:0] dec_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_a_q <= 1'b0;
            dec_cnt <= 8'd0;
        end else begin
            dec_a_q <= a;
            if (a && !dec_a_q) dec_cnt <= b ? dec_cnt - 8'd1 : dec_cnt + 8'd1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // This task starts on the entry cycle of a quarter phase. It checks the
    // phase values at entry and again on the last cycle of the phase.
    task automatic phase(input string tag, input logic [1:0] ab, input int p);
        chk({tag, "_ab_entry"}, {30'd0, a, b}, {30'd0, ab});
        chk({tag, "_pos"}, {24'd0, pos}, p);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick(P - 1);
        chk({tag, "_ab_hold"}, {30'd0, a, b}, {30'd0, ab});
        tick(1);
    endtask

    task automatic detent(input bit cw, input int pb);
        int pa;
        pa = cw ? pb + 1 : pb - 1;
        phase(cw ? "cw_q1" : "ccw_q1", cw ? 2'b10 : 2'b01, cw ? pa : pb);
        phase(cw ? "cw_q2" : "ccw_q2", 2'b11, pa);
        phase(cw ? "cw_q3" : "ccw_q3", cw ? 2'b01 : 2'b10, pa);
        phase(cw ? "cw_q4" : "ccw_q4", 2'b00, pa);
    endtask

    task automatic do_load(input logic [7:0] t);
        target = t;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
    endtask

    task automatic finish_chk(input string tag, input int p);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pos"}, {24'd0, pos}, p);
        tick(1);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic lb_tick();
        logic [1:0] prev;
        prev = {a, b};
        tick(1);
        chk("gray", {31'd0, ($countones(prev ^ {a, b}) <= 1)}, 32'd1);
        if (!busy) chk("loopback", {24'd0, dec_cnt}, {24'd0, pos});
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        load   = 1'b0;
        target = 8'd0;
        tick(2);
        reset = 1'b0;
        chk("rst_state", {28'd0, a, b, busy, done}, 32'd0);
        chk("rst_pos", {24'd0, pos}, 32'd0);

        // Load a target equal to pos while idle: nothing should happen.
        do_load(8'd0);
        for (int i = 0; i < 20; i++) begin
            chk("noop", {28'd0, a, b, busy, done}, 32'd0);
            tick(1);
        end

        // Step up from 0 to 3.
        do_load(8'd3);
        chk("up_lat_busy", {31'd0, busy}, 32'd0);
        tick(1);
        for (int d = 0; d < 3; d++) detent(1'b1, d);
        finish_chk("up", 3);

        // Step down from 3 to 1.
        do_load(8'd1);
        tick(1);
        detent(1'b0, 3);
        detent(1'b0, 2);
        finish_chk("down", 1);

        // Load 1 again while idle (pos=1): no motion.
        do_load(8'd1);
        for (int i = 0; i < 10; i++) begin
            chk("noop1", {29'd0, busy, done, a}, 32'd0);
            tick(1);
        end

        // Assert reset in the middle of a CW Q2.
        do_load(8'd5);
        tick(1);
        phase("rq1", 2'b10, 2);
        chk("rq2_ab", {30'd0, a, b}, 32'd3);
        tick(1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_out", {28'd0, a, b, busy, done}, 32'd0);
        chk("rst_mid_pos", {24'd0, pos}, 32'd0);
        #3 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("post_rst_quiet", {28'd0, a, b, busy, done}, 32'd0);
        end

        // Retarget during Q2 of the first detent: CW toward 5, then 0.
        do_load(8'd5);
        tick(1);
        phase("rt_q1", 2'b10, 1);
        chk("rt_q2_ab", {30'd0, a, b}, 32'd3);
        target = 8'd0;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
        tick(P - 2);
        chk("rt_q2_hold", {30'd0, a, b}, 32'd3);
        tick(1);
        phase("rt_q3", 2'b01, 1);
        phase("rt_q4", 2'b00, 1);
        detent(1'b0, 1);
        finish_chk("retarget", 0);

        // Loopback against the reference decoder with random targets.
        for (int it = 0; it < 8; it++) begin
            int n;
            target = 8'($urandom_range(0, 255));
            load   = 1'b1;
            lb_tick();
            load   = 1'b0;
            n = $urandom_range(0, 600);
            for (int k = 0; k < n; k++) lb_tick();
        end
        for (int i = 0; i < 5000 && busy; i++) lb_tick();
        chk("lb_idle", {31'd0, busy}, 32'd0);
        tick(2);
        chk("lb_final", {24'd0, dec_cnt}, {24'd0, pos});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
